// File: rtl/esm_pkg.sv
// ESM shared types and constants for the status-report path.
// Header layout, error flags and decoder FSM states.
package esm_pkg;

  localparam logic [31:0] esm_report_magic_num = 32'h4553_4D52;
  localparam logic [7:0] esm_report_message_type_status = 8'h01;

  localparam int ESM_STATUS_REPORT_HEADER_WORDS = 7;

  typedef struct packed {
    logic [31:0] magic;
    logic [31:0] seq_num;
    logic [7:0]  module_id;
    logic [7:0]  message_type;
    logic [15:0] pad;
    logic [31:0] enables;
    logic [31:0] status;
    logic [63:0] timestamp;
  } esm_status_report_header_t;

  typedef struct packed {
    logic magic;
    logic type_id;
    logic length;
    logic seq;
    logic padding;
  } esm_status_report_err_t;

  typedef enum logic [1:0] {
    S_HEADER,
    S_PADDING,
    S_DRAIN
  } esm_decoder_state_t;

endpackage

// File: rtl/esm_status_report_decoder_if.sv
// Stream-in / report-out handshake bundle of the status-report decoder.
// slave = decoder side, master = stream source and report consumer.
interface esm_status_report_decoder_if #(
  parameter int DW = 32
);

  logic          Axis_valid;
  logic          Axis_ready;
  logic [DW-1:0] Axis_data;
  logic          Axis_last;

  logic          Report_valid;
  logic          Report_ready;
  logic [31:0]   Report_seq_num;
  logic [31:0]   Report_enables;
  logic [31:0]   Report_status;
  logic [63:0]   Report_timestamp;

  modport master (
    output Axis_valid, Axis_data, Axis_last,
    output Report_ready,
    input  Axis_ready,
    input  Report_valid, Report_seq_num,
    input  Report_enables, Report_status,
    input  Report_timestamp
  );

  modport slave (
    input  Axis_valid, Axis_data, Axis_last,
    input  Report_ready,
    output Axis_ready,
    output Report_valid, Report_seq_num,
    output Report_enables, Report_status,
    output Report_timestamp
  );

endinterface

// File: rtl/esm_report_err_counter.sv
// Saturating error counter, one per decoder error class.
// Sticks at all-ones instead of wrapping.
module esm_report_err_counter #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // count up on each flagged packet, hold at all-ones
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/esm_status_report_decoder.sv
// ESM status-report stream decoder with saturating error counters.
// Padding check enabled by ESM_REPORT_DECODER_PADDING_CHECK_EN.
module esm_status_report_decoder
  import esm_pkg::*;
#(
  parameter int AXI_DATA_WIDTH       = 32,
  parameter int MODULE_ID            = 99,
  parameter int MAX_WORDS_PER_PACKET = 64,
  parameter int COUNTER_WIDTH        = 16
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  esm_status_report_decoder_if.slave bus,
  output logic [COUNTER_WIDTH-1:0] Err_magic_count,
  output logic [COUNTER_WIDTH-1:0] Err_type_count,
  output logic [COUNTER_WIDTH-1:0] Err_length_count,
  output logic [COUNTER_WIDTH-1:0] Err_seq_count,
  output logic [COUNTER_WIDTH-1:0] Err_padding_count
);

  localparam int IW = $clog2(MAX_WORDS_PER_PACKET);
  localparam logic [IW-1:0] LAST_IDX =
    IW'(MAX_WORDS_PER_PACKET - 1);
  localparam logic [IW-1:0] HDR_LAST =
    IW'(ESM_STATUS_REPORT_HEADER_WORDS - 1);
  localparam logic [7:0] MID = 8'(MODULE_ID);

  esm_decoder_state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  esm_status_report_header_t shadow_q;
  esm_status_report_err_t err;

  logic [AXI_DATA_WIDTH-1:0] word;
  logic        live_q, pending_q;
  logic        pad_bad_q, pad_word_bad;
  logic        seq_locked_q;
  logic [31:0] seq_exp_q;
  logic        beat, commit, good;
  logic        magic_ok, type_ok, pad_ok;

  logic [31:0] seq_q, en_q, st_q;
  logic [63:0] ts_q;

  assign word = bus.Axis_data;
  assign beat = bus.Axis_valid && bus.Axis_ready;

  assign bus.Axis_ready       = live_q && !pending_q;
  assign bus.Report_valid     = pending_q;
  assign bus.Report_seq_num   = seq_q;
  assign bus.Report_enables   = en_q;
  assign bus.Report_status    = st_q;
  assign bus.Report_timestamp = ts_q;

  // next state, word index, commit and per-class error flags
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    commit       = 1'b0;
    err          = '0;
    pad_word_bad = 1'b0;
`ifdef ESM_REPORT_DECODER_PADDING_CHECK_EN
    pad_word_bad = (word != '0);
`endif
    if (beat) begin
      unique case (state_q)
        S_HEADER: begin
          if (bus.Axis_last) begin
            err.length = 1'b1;
            idx_d      = '0;
          end else begin
            idx_d = idx_q + IW'(1);
            if (idx_q == HDR_LAST) state_d = S_PADDING;
          end
        end
        S_PADDING: begin
          if (bus.Axis_last) begin
            state_d = S_HEADER;
            idx_d   = '0;
            if (idx_q == LAST_IDX) commit = 1'b1;
            else err.length = 1'b1;
          end else if (idx_q == LAST_IDX) begin
            err.length = 1'b1;
            state_d    = S_DRAIN;
            idx_d      = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
        S_DRAIN: begin
          if (bus.Axis_last) begin
            state_d = S_HEADER;
            idx_d   = '0;
          end
        end
        default: state_d = S_HEADER;
      endcase
    end
    magic_ok = (shadow_q.magic == esm_report_magic_num);
    type_ok  = (shadow_q.message_type ==
                esm_report_message_type_status) &&
               (shadow_q.module_id == MID);
    // the last beat is itself a padding word
    pad_ok   = !(pad_bad_q || pad_word_bad);
    good     = commit && magic_ok && type_ok && pad_ok;
    if (commit) begin
      err.magic   = !magic_ok;
      err.type_id = !type_ok;
      err.padding = !pad_ok;
    end
    err.seq = good && seq_locked_q &&
              (shadow_q.seq_num != seq_exp_q);
  end

  // FSM state, index and padding-violation tracking
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= S_HEADER;
      idx_q     <= '0;
      live_q    <= 1'b0;
      pad_bad_q <= 1'b0;
    end else begin
      live_q  <= 1'b1;
      state_q <= state_d;
      idx_q   <= idx_d;
      if (beat && bus.Axis_last) begin
        pad_bad_q <= 1'b0;
      end else if (beat && state_q == S_PADDING) begin
        pad_bad_q <= pad_bad_q | pad_word_bad;
      end
    end
  end

  // header words land in the shadow as they arrive
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      shadow_q <= '0;
    end else if (beat && state_q == S_HEADER) begin
      unique case (1'b1)
        (idx_q == IW'(0)): shadow_q.magic   <= word[31:0];
        (idx_q == IW'(1)): shadow_q.seq_num <= word[31:0];
        (idx_q == IW'(2)): begin
          shadow_q.module_id    <= word[31:24];
          shadow_q.message_type <= word[23:16];
          shadow_q.pad          <= word[15:0];
        end
        (idx_q == IW'(3)): shadow_q.enables <= word[31:0];
        (idx_q == IW'(4)): shadow_q.status  <= word[31:0];
        (idx_q == IW'(5)):
          shadow_q.timestamp[63:32] <= word[31:0];
        (idx_q == IW'(6)):
          shadow_q.timestamp[31:0] <= word[31:0];
        default: ;
      endcase
    end
  end

  // report registers, pending flag and sequence tracker
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pending_q    <= 1'b0;
      seq_locked_q <= 1'b0;
      seq_exp_q    <= '0;
      seq_q        <= '0;
      en_q         <= '0;
      st_q         <= '0;
      ts_q         <= '0;
    end else if (good) begin
      pending_q    <= 1'b1;
      seq_locked_q <= 1'b1;
      seq_exp_q    <= shadow_q.seq_num + 32'd1;
      seq_q        <= shadow_q.seq_num;
      en_q         <= shadow_q.enables;
      st_q         <= shadow_q.status;
      ts_q         <= shadow_q.timestamp;
    end else if (pending_q && bus.Report_ready) begin
      pending_q <= 1'b0;
    end
  end

  esm_report_err_counter #(.W(COUNTER_WIDTH)) u_cnt_magic (
    .Clk(Clk), .Rst_n(Rst_n),
    .inc(err.magic), .count(Err_magic_count)
  );

  esm_report_err_counter #(.W(COUNTER_WIDTH)) u_cnt_type (
    .Clk(Clk), .Rst_n(Rst_n),
    .inc(err.type_id), .count(Err_type_count)
  );

  esm_report_err_counter #(.W(COUNTER_WIDTH)) u_cnt_length (
    .Clk(Clk), .Rst_n(Rst_n),
    .inc(err.length), .count(Err_length_count)
  );

  esm_report_err_counter #(.W(COUNTER_WIDTH)) u_cnt_seq (
    .Clk(Clk), .Rst_n(Rst_n),
    .inc(err.seq), .count(Err_seq_count)
  );

  // never increments when the padding check is compiled out
  esm_report_err_counter #(.W(COUNTER_WIDTH)) u_cnt_padding (
    .Clk(Clk), .Rst_n(Rst_n),
    .inc(err.padding), .count(Err_padding_count)
  );

endmodule
